eeprom_slave_model: RTL and testbench



---
 rtl/eeprom_slave_model.sv | 212 +++++++++++++++++++++
 tb/tb_eeprom_slave_model.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_slave_model.sv
// eeprom_slave_model
//   Device side of a two-wire serial EEPROM bus, modelling a 24C16-class
//   2 KB part. SCL/SDA are oversampled with CLK, which must run at least
//   8x the SCL rate. START/STOP, the control byte, the word address and
//   data bytes are decoded and acknowledged. Write data is stored in an
//   internal array, and read data is shifted out MSB first.
//
//   Optional build macro: EEPROM_SLAVE_WP_EN adds a write-protect input.
//
// Ports
//   CLK      in     system clock
//   RESET    in     synchronous, active-high reset
//   WP       in     write protect (only with EEPROM_SLAVE_WP_EN)
//   SCL      in     serial clock from the master
//   SDA      inout  serial data, open drain (this block only pulls low)
//   BUSY     out    high from START until STOP or reset
//   WR_DONE  out    one-CLK pulse per data byte committed to memory
module eeprom_slave_model #(
  parameter logic [3:0] DEV_TYPE = 4'b1010,
  parameter int         ADDR_W   = 11,
  parameter int         PAGE_W   = 4
) (
  input  logic CLK,
  input  logic RESET,
`ifdef EEPROM_SLAVE_WP_EN
  input  logic WP,
`endif
  input  logic SCL,
  inout  wire  SDA,
  output logic BUSY,
  output logic WR_DONE
);

  typedef enum logic [3:0] {
    IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  logic wp_active;
`ifdef EEPROM_SLAVE_WP_EN
  assign wp_active = WP;
`else
  assign wp_active = 1'b0;
`endif

  // Two-flop synchronizers plus one history flop. The edge and condition
  // flags are registered, so the FSM acts one CLK after an edge is seen.
  logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values that were present before the clock edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
      scl_rise <= 1'b0; scl_fall <= 1'b0; start_det <= 1'b0; stop_det <= 1'b0;
    end else begin
      scl_s1    <= SCL;    scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1    <= SDA;    sda_s2 <= sda_s1; sda_d <= sda_s2;
      scl_rise  <=  scl_s2 & ~scl_d;
      scl_fall  <= ~scl_s2 &  scl_d;
      start_det <=  scl_s2 &  scl_d &  sda_d & ~sda_s2;
      stop_det  <=  scl_s2 &  scl_d & ~sda_d &  sda_s2;
    end
  end

  state_t            state, state_nx;
  logic [3:0]        bit_cnt, bit_cnt_nx;
  logic [7:0]        shreg, shreg_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic              oe, oe_nx, busy_nx, wr_done_nx, mem_we;
  logic [7:0]        byte_in, rd_byte;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  // When the FSM sees scl_rise, sda_d holds SDA as sampled at that rising edge.
  assign byte_in = {shreg[6:0], sda_d};
  assign rd_byte = mem[ptr];

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    ptr_nx     = ptr;
    oe_nx      = oe;
    busy_nx    = BUSY;
    wr_done_nx = 1'b0;
    mem_we     = 1'b0;
    if (stop_det) begin
      state_nx = IDLE; oe_nx = 1'b0; busy_nx = 1'b0; bit_cnt_nx = 4'd0;
    end else if (start_det) begin
      // Covers both START and repeated START; a partial byte is discarded.
      state_nx = CTRL; oe_nx = 1'b0; busy_nx = 1'b1; bit_cnt_nx = 4'd0;
    end else begin
      case (state)
        CTRL, ADDR, WDATA: if (scl_rise) begin
          shreg_nx   = byte_in;
          bit_cnt_nx = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_nx = 4'd0;
            if (state == CTRL) begin
              if (byte_in[7:4] == DEV_TYPE) begin
                state_nx = CTRL_ACK;
                ptr_nx[ADDR_W-1 -: 3] = byte_in[3:1];
              end else begin
                state_nx = WAIT_STOP;
              end
            end else if (state == ADDR) begin
              state_nx    = ADDR_ACK;
              ptr_nx[7:0] = byte_in;
            end else begin
              state_nx = WDATA_ACK;
              if (!wp_active) begin
                mem_we     = 1'b1;
                wr_done_nx = 1'b1;
                // Writes wrap inside the current page.
                ptr_nx[PAGE_W-1:0] = ptr[PAGE_W-1:0] + PAGE_W'(1);
              end
            end
          end
        end
        // bit_cnt 0 -> waiting for the fall that opens the ACK slot,
        // bit_cnt 1 -> waiting for the fall that closes it.
        CTRL_ACK, ADDR_ACK, WDATA_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd0) begin
            bit_cnt_nx = 4'd1;
            oe_nx      = !(state == WDATA_ACK && wp_active);
          end else begin
            bit_cnt_nx = 4'd0;
            oe_nx      = 1'b0;
            if (state == CTRL_ACK) begin
              if (shreg[0]) begin
                // Read: bit 7 goes out on the same fall that ends the ACK.
                state_nx = RDATA;
                shreg_nx = rd_byte;
                oe_nx    = ~rd_byte[7];
              end else begin
                state_nx = ADDR;
              end
            end else if (state == ADDR_ACK) begin
              state_nx = WDATA;
            end else begin
              state_nx = wp_active ? WAIT_STOP : WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_nx   = RACK;
              oe_nx      = 1'b0;
              bit_cnt_nx = 4'd0;
              ptr_nx     = ptr + ADDR_W'(1);
            end else if (bit_cnt != 4'd0) begin
              shreg_nx = {shreg[6:0], shreg[7]};
              oe_nx    = ~shreg[6];
            end
          end
        end
        RACK: begin
          // bit 1 = master ACK slot sampled, bit 0 = sampled SDA level.
          if (scl_rise) begin
            bit_cnt_nx = {2'b00, 1'b1, sda_d};
          end else if (scl_fall && bit_cnt[1]) begin
            bit_cnt_nx = 4'd0;
            if (!bit_cnt[0]) begin
              state_nx = RDATA;
              shreg_nx = rd_byte;
              oe_nx    = ~rd_byte[7];
            end else begin
              state_nx = WAIT_STOP;
            end
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'd0;
      ptr     <= '0;
      oe      <= 1'b0;
      BUSY    <= 1'b0;
      WR_DONE <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      ptr     <= ptr_nx;
      oe      <= oe_nx;
      BUSY    <= busy_nx;
      WR_DONE <= wr_done_nx;
    end
  end

  // NOTE: the storage array has no reset; contents survive RESET like a
  // real non-volatile part.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) mem[ptr] <= byte_in;
  end

  assign SDA = oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_eeprom_slave_model.sv
// tb_eeprom_slave_model
//   Directed bench for eeprom_slave_model. A bus master built from tasks
//   drives SCL and an open-drain SDA. The bench checks the ACK slots, read
//   data, BUSY and WR_DONE, and the memory contents against hand-computed
//   values.
module tb_eeprom_slave_model;

  logic clk = 1'b0;
  logic reset, scl, m_oe;
  logic busy, wr_done;
  wire  sda_line;
`ifdef EEPROM_SLAVE_WP_EN
  logic wp;
`endif

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int slave_low_cnt = 0;

  pullup (sda_line);
  assign sda_line = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  eeprom_slave_model dut (
    .CLK     (clk),
    .RESET   (reset),
`ifdef EEPROM_SLAVE_WP_EN
    .WP      (wp),
`endif
    .SCL     (scl),
    .SDA     (sda_line),
    .BUSY    (busy),
    .WR_DONE (wr_done)
  );

  always @(posedge clk) begin
    if (wr_done === 1'b1) wr_cnt <= wr_cnt + 1;
    if (sda_line === 1'b0 && m_oe === 1'b0) slave_low_cnt <= slave_low_cnt + 1;
  end

  // One SCL period of 150 ns: 100 ns low (master data changes at +60), 50 ns high.
  task automatic clk_bit(input logic drive_low, output logic s);
    #60 m_oe = drive_low;
    #40 scl  = 1'b1;
    #30 s    = sda_line;
    #20 scl  = 1'b0;
  endtask

  task automatic bus_start();
    #60 m_oe = 1'b0;
    #40 scl  = 1'b1;
    #40 m_oe = 1'b1;
    #40 scl  = 1'b0;
  endtask

  task automatic bus_stop();
    #60 m_oe = 1'b1;
    #40 scl  = 1'b1;
    #40 m_oe = 1'b0;
    #40;
  endtask

  // Sends a byte and returns the level of the ninth (ACK) clock. lat is the
  // number of CLK rising edges from the eighth SCL fall until SDA goes low (0 = never).
  task automatic send_byte(input logic [7:0] b, output logic ack, output int lat);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(!b[i], s);
    m_oe = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (lat == 0 && sda_line === 1'b0) lat = n;
    end
    #4;
    #40 scl = 1'b1;
    #30 ack = sda_line;
    #20 scl = 1'b0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b0, s);
      d[i] = s;
    end
    clk_bit(mack, s);
  endtask

  task automatic test_reset();
    reset = 1'b1; scl = 1'b1; m_oe = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (wr_done !== 1'b0) begin miscompares++; $display("FAIL reset_wr_done: got %b want 0", wr_done); end
    vectors++; if (sda_line !== 1'b1) begin miscompares++; $display("FAIL reset_sda: got %b want 1", sda_line); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_byte_write();
    logic ack; int lat; int wr0;
    wr0 = wr_cnt;
    bus_start();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bw_busy_start: got %b want 1", busy); end
    send_byte(8'hA6, ack, lat);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL bw_ctrl_ack: got %b want 0", ack); end
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL bw_ack_latency: got %0d want 4", lat); end
    send_byte(8'h5C, ack, lat);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL bw_addr_ack: got %b want 0", ack); end
    send_byte(8'h3C, ack, lat);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL bw_data_ack: got %b want 0", ack); end
    bus_stop();
    #20;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bw_busy_stop: got %b want 0", busy); end
    vectors++; if (wr_cnt - wr0 !== 1) begin miscompares++; $display("FAIL bw_wr_done_count: got %0d want 1", wr_cnt - wr0); end
    vectors++; if (dut.mem[11'h35C] !== 8'h3C) begin miscompares++; $display("FAIL bw_mem_35c: got %h want 3c", dut.mem[11'h35C]); end
  endtask

  task automatic test_random_read();
    logic ack; int lat; logic [7:0] d;
    bus_start();
    send_byte(8'hA6, ack, lat);
    send_byte(8'h5C, ack, lat);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rr_addr_ack: got %b want 0", ack); end
    bus_start();
    send_byte(8'hA7, ack, lat);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rr_ctrl_ack: got %b want 0", ack); end
    read_byte(1'b0, d);
    vectors++; if (d !== 8'h3C) begin miscompares++; $display("FAIL rr_data: got %h want 3c", d); end
    bus_stop();
    #20;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_busy_stop: got %b want 0", busy); end
    vectors++; if (sda_line !== 1'b1) begin miscompares++; $display("FAIL rr_sda_released: got %b want 1", sda_line); end
  endtask

  task automatic test_page_wrap();
    logic ack; int lat; int wr0;
    bus_start();
    send_byte(8'hA0, ack, lat);
    send_byte(8'h10, ack, lat);
    send_byte(8'h99, ack, lat);
    bus_stop();
    wr0 = wr_cnt;
    bus_start();
    send_byte(8'hA0, ack, lat);
    send_byte(8'h0E, ack, lat);
    send_byte(8'h11, ack, lat);
    send_byte(8'h22, ack, lat);
    send_byte(8'h33, ack, lat);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL pw_third_ack: got %b want 0", ack); end
    bus_stop();
    #20;
    vectors++; if (dut.mem[11'h00E] !== 8'h11) begin miscompares++; $display("FAIL pw_mem_00e: got %h want 11", dut.mem[11'h00E]); end
    vectors++; if (dut.mem[11'h00F] !== 8'h22) begin miscompares++; $display("FAIL pw_mem_00f: got %h want 22", dut.mem[11'h00F]); end
    vectors++; if (dut.mem[11'h000] !== 8'h33) begin miscompares++; $display("FAIL pw_mem_000: got %h want 33", dut.mem[11'h000]); end
    vectors++; if (dut.mem[11'h010] !== 8'h99) begin miscompares++; $display("FAIL pw_mem_010: got %h want 99", dut.mem[11'h010]); end
    vectors++; if (wr_cnt - wr0 !== 3) begin miscompares++; $display("FAIL pw_wr_done_count: got %0d want 3", wr_cnt - wr0); end
  endtask

  task automatic test_seq_read_wrap();
    logic ack; int lat; logic [7:0] d;
    bus_start();
    send_byte(8'hAE, ack, lat);
    send_byte(8'hFF, ack, lat);
    send_byte(8'h5A, ack, lat);
    bus_stop();
    bus_start();
    send_byte(8'hAE, ack, lat);
    send_byte(8'hFF, ack, lat);
    bus_start();
    send_byte(8'hAF, ack, lat);
    read_byte(1'b1, d);
    vectors++; if (d !== 8'h5A) begin miscompares++; $display("FAIL sr_byte_7ff: got %h want 5a", d); end
    read_byte(1'b0, d);
    vectors++; if (d !== 8'h33) begin miscompares++; $display("FAIL sr_byte_000: got %h want 33", d); end
    bus_stop();
  endtask

  task automatic test_wrong_device();
    logic ack; int lat; int wr0; int low0;
    wr0 = wr_cnt;
    #20;
    low0 = slave_low_cnt;
    bus_start();
    send_byte(8'h56, ack, lat);
    vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL wd_ctrl_nack: got %b want 1", ack); end
    send_byte(8'h3C, ack, lat);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wd_busy_held: got %b want 1", busy); end
    bus_stop();
    #20;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wd_busy_stop: got %b want 0", busy); end
    vectors++; if (slave_low_cnt - low0 !== 0) begin miscompares++; $display("FAIL wd_sda_pulled: got %0d cycles want 0", slave_low_cnt - low0); end
    vectors++; if (wr_cnt - wr0 !== 0) begin miscompares++; $display("FAIL wd_wr_done_count: got %0d want 0", wr_cnt - wr0); end
    vectors++; if (dut.mem[11'h35C] !== 8'h3C) begin miscompares++; $display("FAIL wd_mem_35c: got %h want 3c", dut.mem[11'h35C]); end
  endtask

  task automatic test_reset_mid_read();
    logic ack; int lat; logic [7:0] d;
    bus_start();
    send_byte(8'hA6, ack, lat);
    send_byte(8'h5C, ack, lat);
    bus_start();
    send_byte(8'hA7, ack, lat);
    #50;
    vectors++; if (sda_line !== 1'b0) begin miscompares++; $display("FAIL rm_driving_bit7: got %b want 0", sda_line); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if (sda_line !== 1'b1) begin miscompares++; $display("FAIL rm_sda_release: got %b want 1", sda_line); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    bus_stop();
    vectors++; if (dut.mem[11'h35C] !== 8'h3C) begin miscompares++; $display("FAIL rm_mem_35c: got %h want 3c", dut.mem[11'h35C]); end
    bus_start();
    send_byte(8'hA6, ack, lat);
    send_byte(8'h5C, ack, lat);
    bus_start();
    send_byte(8'hA7, ack, lat);
    read_byte(1'b0, d);
    vectors++; if (d !== 8'h3C) begin miscompares++; $display("FAIL rm_reread: got %h want 3c", d); end
    bus_stop();
  endtask

`ifdef EEPROM_SLAVE_WP_EN
  task automatic test_write_protect();
    logic ack; int lat; int wr0;
    wr0 = wr_cnt;
    wp  = 1'b1;
    bus_start();
    send_byte(8'hA0, ack, lat);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL wp_ctrl_ack: got %b want 0", ack); end
    send_byte(8'h10, ack, lat);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL wp_addr_ack: got %b want 0", ack); end
    send_byte(8'h77, ack, lat);
    vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL wp_data_nack: got %b want 1", ack); end
    bus_stop();
    #20;
    vectors++; if (dut.mem[11'h010] !== 8'h99) begin miscompares++; $display("FAIL wp_mem_010: got %h want 99", dut.mem[11'h010]); end
    vectors++; if (wr_cnt - wr0 !== 0) begin miscompares++; $display("FAIL wp_wr_done_count: got %0d want 0", wr_cnt - wr0); end
    wp = 1'b0;
  endtask
`endif

  initial begin
`ifdef EEPROM_SLAVE_WP_EN
    wp = 1'b0;
`endif
    test_reset();
    test_byte_write();
    test_random_read();
    test_page_wrap();
    test_seq_read_wrap();
    test_wrong_device();
    test_reset_mid_read();
`ifdef EEPROM_SLAVE_WP_EN
    test_write_protect();
`endif
    #100;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
